// File: rtl/result_ser_pkg.sv
// -----------------------------------------------------------------------------
// result_ser_pkg
// Shared types and constants for the result serializer.
//   ser_state_t      : frame FSM states (IDLE, HDR, PAY, CHK)
//   RES_W_DEF        : default width of one result bus (multiple of 8)
//   NUM_RES_DEF      : default number of result buses per frame
//   HDR_BYTE_DEF     : default first byte of every frame
//   BYTES_PER_RES    : bytes needed to send one result bus
//   FRAME_PAY_BYTES  : payload bytes per frame (header/checksum excluded)
// -----------------------------------------------------------------------------
package result_ser_pkg;

  localparam int         RES_W_DEF       = 24;
  localparam int         NUM_RES_DEF     = 4;
  localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
  localparam int         BYTES_PER_RES   = RES_W_DEF / 8;
  localparam int         FRAME_PAY_BYTES = NUM_RES_DEF * BYTES_PER_RES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/result_serializer.sv
// -----------------------------------------------------------------------------
// result_serializer
// Snapshots the four counter result buses on a capture request and streams
// them out as a framed byte stream over a valid/ready interface:
//   HDR_BYTE, res_sah[MSB..LSB], res_sal, res_aah, res_aal [, checksum]
//
// Optional feature (macro RESULT_SER_CHECKSUM_EN):
//   defined   : a trailing byte holding the XOR of all payload bytes is sent
//   undefined : the frame ends after the last payload byte
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   res_sah/sal/aah/aal  result buses (RES_W bits each), sampled on capture
//   capture_req  single-cycle capture/start pulse
//   tx_data      outgoing byte
//   tx_valid     tx_data is valid
//   tx_ready     sink accepts the byte this cycle
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last byte of a frame is accepted
//   overrun      sticky: a capture_req arrived while busy and was dropped
// -----------------------------------------------------------------------------
module result_serializer
  import result_ser_pkg::*;
#(
  parameter int         RES_W    = RES_W_DEF,
  parameter int         NUM_RES  = NUM_RES_DEF,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] res_sah,
  input  logic [RES_W-1:0] res_sal,
  input  logic [RES_W-1:0] res_aah,
  input  logic [RES_W-1:0] res_aal,
  input  logic             capture_req,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int PAY_BYTES = NUM_RES * (RES_W / 8);
  localparam int PAY_W     = NUM_RES * RES_W;
  localparam int IDX_W     = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_BYTES - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] byte_idx_next;
  logic [PAY_W-1:0] shadow;
  logic [7:0]       pay_byte;
  logic             load_snapshot;
  logic             last_xfer;
  logic             overrun_set;

`ifdef RESULT_SER_CHECKSUM_EN
  logic [7:0]       chk_acc;
  logic [7:0]       chk_acc_next;
`endif

  // Payload byte selected by the byte index; index 0 is the MSB byte of the
  // first result in the snapshot.
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < PAY_BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        pay_byte = shadow[PAY_W-1-8*i -: 8];
      end
    end
  end

  // Next-state and output logic. tx_valid/tx_data are pure functions of
  // registered state, so they stay stable while the sink stalls.
  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    load_snapshot = 1'b0;
    last_xfer     = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;

    case (state)
      IDLE: begin
        if (capture_req) begin
          state_next    = HDR;
          load_snapshot = 1'b1;
        end
      end

      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) begin
          state_next = PAY;
        end
      end

      PAY: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
        if (tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            byte_idx_next = '0;
`ifdef RESULT_SER_CHECKSUM_EN
            state_next    = CHK;
`else
            state_next    = IDLE;
            last_xfer     = 1'b1;
`endif
          end else begin
            byte_idx_next = byte_idx + 1'b1;
          end
        end
      end

`ifdef RESULT_SER_CHECKSUM_EN
      CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk_acc;
        if (tx_ready) begin
          state_next = IDLE;
          last_xfer  = 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // A request landing on the final-byte accept edge starts the next frame
    // immediately instead of being counted as an overrun.
    if (last_xfer && capture_req) begin
      state_next    = HDR;
      load_snapshot = 1'b1;
    end
  end

  assign overrun_set = capture_req && (state != IDLE) && !last_xfer;
  assign busy        = (state != IDLE);

`ifdef RESULT_SER_CHECKSUM_EN
  // Running XOR of accepted payload bytes; cleared when a new snapshot loads.
  always_comb begin
    chk_acc_next = chk_acc;
    if (load_snapshot) begin
      chk_acc_next = '0;
    end else if (state == PAY && tx_ready) begin
      chk_acc_next = chk_acc ^ pay_byte;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      shadow     <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef RESULT_SER_CHECKSUM_EN
      chk_acc    <= '0;
`endif
    end else begin
      state      <= state_next;
      byte_idx   <= byte_idx_next;
      frame_done <= last_xfer;
      if (load_snapshot) begin
        shadow <= {res_sah, res_sal, res_aah, res_aal};
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end
`ifdef RESULT_SER_CHECKSUM_EN
      chk_acc    <= chk_acc_next;
`endif
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_result_serializer
// Self-checking bench for result_serializer. Expected frames are built from
// the result values with plain shifts and XOR; follows RESULT_SER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_result_serializer;

  localparam int RES_W = 24;
`ifdef RESULT_SER_CHECKSUM_EN
  localparam int FRAME_LEN = 14;
`else
  localparam int FRAME_LEN = 13;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [RES_W-1:0] res_sah, res_sal, res_aah, res_aal;
  logic             capture_req;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             frame_done;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         done_seen;

  typedef struct {
    logic [RES_W-1:0] sah, sal, aah, aal;
    int               mode;
    bit               mutate;
    logic [7:0]       exp_xor;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  result_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .res_sah     (res_sah),
    .res_sal     (res_sal),
    .res_aah     (res_aah),
    .res_aal     (res_aal),
    .capture_req (capture_req),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic rdy);
    capture_req = cap;
    tx_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic setResults(input logic [RES_W-1:0] a, b, c, d);
    res_sah = a;
    res_sal = b;
    res_aah = c;
    res_aal = d;
  endtask

  function automatic void buildExpected(input logic [RES_W-1:0] v0, v1, v2, v3);
    logic [RES_W-1:0] vals[4];
    logic [7:0]       x;
    logic [7:0]       b;
    vals = '{v0, v1, v2, v3};
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = 8'h00;
    for (int r = 0; r < 4; r++) begin
      for (int k = RES_W/8 - 1; k >= 0; k--) begin
        b = 8'((vals[r] >> (8*k)) & 24'hFF);
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef RESULT_SER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  // Collects one frame; mode 0 = ready high, 1 = toggle starting low, 2 = random.
  // cap_at >= 0 raises capture_req on the cycle byte number cap_at is accepted.
  task automatic streamFrame(input int mode, input bit mutate, input int cap_at,
                             input string tag, output int valid_cycles);
    logic       prev_stall;
    logic [7:0] prev_data;
    bit         injected;
    int         cyc;
    got.delete();
    done_seen    = 0;
    valid_cycles = 0;
    prev_stall   = 1'b0;
    prev_data    = 8'h00;
    injected     = 1'b0;
    for (cyc = 0; cyc < 400 && got.size() < FRAME_LEN; cyc++) begin
      logic rdy;
      logic cap;
      if (cyc > 0 && frame_done) done_seen++;
      if (prev_stall) begin
        checkOutput($sformatf("%s stall_valid", tag), 32'(tx_valid), 32'd1);
        checkOutput($sformatf("%s stall_data", tag), 32'(tx_data), 32'(prev_data));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (mutate && cyc == 0) setResults('1, '1, '1, '1);
      cap = 1'b0;
      if (cap_at >= 0 && !injected && tx_valid && rdy && got.size() == cap_at) begin
        cap      = 1'b1;
        injected = 1'b1;
      end
      if (tx_valid) valid_cycles++;
      if (tx_valid && rdy) got.push_back(tx_data);
      prev_stall = tx_valid && !rdy;
      prev_data  = tx_data;
      applyStimulus(cap, rdy);
    end
    checkOutput($sformatf("%s frame_len", tag), 32'(got.size()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hxx;
      checkOutput($sformatf("%s byte%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
    checkOutput($sformatf("%s early_done", tag), 32'(done_seen), 32'd0);
    checkOutput($sformatf("%s frame_done", tag), 32'(frame_done), 32'd1);
  endtask

  initial begin
    int vc;
    vecs[0] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 0, 1'b0, 8'h0C};
    vecs[1] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 1, 1'b0, 8'h0C};
    vecs[2] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 0, 1'b1, 8'h0C};
    vecs[3] = '{24'h123456, 24'h000000, 24'h000000, 24'h000000, 2, 1'b0, 8'h70};
    vecs[4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 0, 1'b0, 8'hFF};

    rst         = 1'b1;
    capture_req = 1'b0;
    tx_ready    = 1'b0;
    setResults('0, '0, '0, '0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    rst = 1'b0;
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);

    // Table: basic, backpressure, snapshot integrity, plus two patterns.
    for (int v = 0; v < 5; v++) begin
      setResults(vecs[v].sah, vecs[v].sal, vecs[v].aah, vecs[v].aal);
      buildExpected(vecs[v].sah, vecs[v].sal, vecs[v].aah, vecs[v].aal);
      applyStimulus(1, 1);
      checkOutput($sformatf("vec%0d latency_hdr", v), 32'(tx_data), 32'h0A5);
      streamFrame(vecs[v].mode, vecs[v].mutate, -1, $sformatf("vec%0d", v), vc);
`ifdef RESULT_SER_CHECKSUM_EN
      checkOutput($sformatf("vec%0d xor", v), 32'(got[FRAME_LEN-1]), 32'(vecs[v].exp_xor));
`endif
      if (vecs[v].mode == 1)
        checkOutput($sformatf("vec%0d bp_cycles", v), 32'(vc), 32'(2*FRAME_LEN));
      applyStimulus(0, 1);
      checkOutput($sformatf("vec%0d done_clear", v), 32'(frame_done), 32'd0);
      checkOutput($sformatf("vec%0d idle", v), 32'(busy), 32'd0);
    end
    checkOutput("no overrun yet", 32'(overrun), 32'd0);

    // Overrun: request during byte 5 is dropped, frame unchanged.
    setResults(24'hAABBCC, 24'h112233, 24'h445566, 24'h778899);
    buildExpected(24'hAABBCC, 24'h112233, 24'h445566, 24'h778899);
    applyStimulus(1, 1);
    streamFrame(0, 1'b0, 5, "ovr", vc);
    checkOutput("ovr flag", 32'(overrun), 32'd1);
    applyStimulus(0, 1);
    checkOutput("ovr idle", 32'(busy), 32'd0);

    // Random frames; overrun must stay sticky throughout.
    for (int n = 0; n < 4; n++) begin
      logic [RES_W-1:0] r0, r1, r2, r3;
      r0 = RES_W'($urandom); r1 = RES_W'($urandom);
      r2 = RES_W'($urandom); r3 = RES_W'($urandom);
      setResults(r0, r1, r2, r3);
      buildExpected(r0, r1, r2, r3);
      applyStimulus(1, 1);
      streamFrame(2, 1'b0, -1, $sformatf("rnd%0d", n), vc);
      checkOutput($sformatf("rnd%0d ovr_sticky", n), 32'(overrun), 32'd1);
      applyStimulus(0, 1);
    end

    // Reset mid-frame at byte 7.
    setResults(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    buildExpected(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    applyStimulus(1, 1);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1);
    checkOutput("rstmid byte7", 32'(tx_data), 32'(exp_q[7]));
    rst = 1'b1;
    applyStimulus(0, 1);
    rst = 1'b0;
    checkOutput("rstmid tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rstmid busy", 32'(busy), 32'd0);
    checkOutput("rstmid overrun", 32'(overrun), 32'd0);
    checkOutput("rstmid frame_done", 32'(frame_done), 32'd0);
    applyStimulus(0, 1);
    checkOutput("rstmid no_done", 32'(frame_done), 32'd0);
    applyStimulus(1, 1);
    streamFrame(0, 1'b0, -1, "fresh", vc);
    applyStimulus(0, 1);

    // Back-to-back: capture on the final accept edge; inputs change to all-ones
    // after the first capture so the second snapshot differs.
    setResults(24'h0F1E2D, 24'h3C4B5A, 24'h697887, 24'h96A5B4);
    buildExpected(24'h0F1E2D, 24'h3C4B5A, 24'h697887, 24'h96A5B4);
    applyStimulus(1, 1);
    streamFrame(0, 1'b1, FRAME_LEN-1, "b2b1", vc);
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b hdr_valid", 32'(tx_valid), 32'd1);
    checkOutput("b2b hdr", 32'(tx_data), 32'h0A5);
    checkOutput("b2b overrun", 32'(overrun), 32'd0);
    buildExpected('1, '1, '1, '1);
    streamFrame(0, 1'b0, -1, "b2b2", vc);
    applyStimulus(0, 1);
    checkOutput("b2b2 done_clear", 32'(frame_done), 32'd0);
    checkOutput("b2b2 overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
